// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores over a word-wide port,
// sub-word stores by read-modify-write. Optional trace output under DMCTRL_TRACE_EN.
module dm_access_ctrl #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_DMWr,
  output logic          mem_MemR,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e        state_q, state_d;
  logic          we_q, signed_q, err_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;  // bits above the word address are ignored, so not kept
  logic [31:0]   wdata_q, rbuf_q;

  logic          accept, req_err;
  logic [31:0]   merged, ext;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                           state_d = StResp;
          else if (req_we && req_size == 2'b10)  state_d = StWr;
          else                                   state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr[AW+1:0];
        wdata_q  <= req_wdata;
      end
      if (state_q == StRd) rbuf_q <= mem_dout;
    end
  end

  // Store merge: replace the addressed lane of the previously read word.
  always_comb begin
    merged = rbuf_q;
    case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  assign lane_b = rbuf_q[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = addr_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];

  always_comb begin
    ext = '0;
    if (state_q == StResp && !err_q && !we_q) begin
      case (size_q)
        2'b00:   ext = {{24{signed_q & lane_b[7]}}, lane_b};
        2'b01:   ext = {{16{signed_q & lane_h[15]}}, lane_h};
        default: ext = rbuf_q;
      endcase
    end
  end

  assign mem_MemR   = (state_q == StRd);
  assign mem_DMWr   = (state_q == StWr);
  assign mem_addr   = (mem_MemR || mem_DMWr) ? addr_q[AW+1:2] : '0;
  assign mem_din    = mem_DMWr ? merged : '0;
  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = ext;

`ifdef DMCTRL_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && mem_DMWr) $display("dm_access_ctrl: write mem[%0d] = 0x%08h", mem_addr, mem_din);
    if (rst_n && resp_valid && resp_err)
      $display("dm_access_ctrl: error response addr=0x%0h size=%b", addr_q, size_q);
  end
`else
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a 32-word behavioural memory.
module tb_dm_access_ctrl;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;
  logic          mem_DMWr, mem_MemR;

  logic [31:0]   mem [32];

  int checks = 0;
  int errors = 0;

  // Results of the most recent transaction
  logic        r_got, r_err, r_busy, r_after;
  logic [31:0] r_data;
  int          r_lat, r_nwr, r_nrd;
  logic        seen;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_DMWr) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  dm_access_ctrl #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_DMWr   (mem_DMWr),
    .mem_MemR   (mem_MemR),
    .mem_dout   (mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_got = 1'b0; r_err = 1'b0; r_data = '0; r_lat = 0; r_nwr = 0; r_nrd = 0;
    r_busy = 1'b0; r_after = 1'b0;
    for (int i = 1; i <= 8 && !r_got; i++) begin
      @(negedge clk);
      if (i == 1) r_busy = !req_ready;
      if (mem_DMWr) r_nwr++;
      if (mem_MemR) r_nrd++;
      if (resp_valid) begin
        r_got  = 1'b1;
        r_lat  = i;
        r_data = resp_rdata;
        r_err  = resp_err;
      end
    end
    check("resp_seen", {31'b0, r_got}, 32'd1);
    @(negedge clk);
    r_after = resp_valid;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'b0, req_ready},  32'd1);
    check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata",  resp_rdata,          32'd0);
    check("rst_strobe", {30'b0, mem_DMWr, mem_MemR}, 32'd0);
    check("rst_maddr",  {27'b0, mem_addr},   32'd0);
    check("rst_mdin",   mem_din,             32'd0);
    rst_n = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF);
    check("wst_lat",   r_lat, 2);
    check("wst_nwr",   r_nwr, 1);
    check("wst_nrd",   r_nrd, 0);
    check("wst_err",   {31'b0, r_err}, 32'd0);
    check("wst_busy",  {31'b0, r_busy}, 32'd1);
    check("wst_pulse", {31'b0, r_after}, 32'd0);
    check("wst_mem3",  mem[3], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    check("wld_lat",  r_lat, 2);
    check("wld_nrd",  r_nrd, 1);
    check("wld_data", r_data, 32'hDEAD_BEEF);
    check("wld_err",  {31'b0, r_err}, 32'd0);

    // Byte store read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AA);
    check("bst_lat",  r_lat, 3);
    check("bst_nrd",  r_nrd, 1);
    check("bst_nwr",  r_nwr, 1);
    check("bst_data", r_data, 32'h0);
    check("bst_mem1", mem[1], 32'h11AA_3344);

    // Sub-word loads with extension
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h8000_F0FF);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0008, 32'h0);
    check("lb_s",  r_data, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0);
    check("lb_u",  r_data, 32'h0000_00FF);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0);
    check("lb_s3", r_data, 32'hFFFF_FF80);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
    check("lh_s",  r_data, 32'hFFFF_8000);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0);
    check("lh_u",  r_data, 32'h0000_F0FF);
    check("lh_lat", r_lat, 2);

    // Halfword store into upper lane
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'hFFFF_1234);
    check("hst_mem3", mem[3], 32'h1234_BEEF);

    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
    check("mis_w_err",  {31'b0, r_err}, 32'd1);
    check("mis_w_lat",  r_lat, 1);
    check("mis_w_data", r_data, 32'h0);
    check("mis_w_nrd",  r_nrd, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0123_4567);
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_BEEF);
    check("mis_h_err",  {31'b0, r_err}, 32'd1);
    check("mis_h_nwr",  r_nwr, 0);
    check("mis_h_mem0", mem[0], 32'h0123_4567);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    check("rsv_err", {31'b0, r_err}, 32'd1);
    check("rsv_nrd", r_nrd, 0);

    // Address wrap modulo depth
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0084, 32'h0000_0055);
    check("wrap_mem1", mem[1], 32'h0000_0055);

    // Reset during the write phase of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h0000_0006; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rr_memr", {31'b0, mem_MemR}, 32'd1);
    @(negedge clk);
    check("rr_dmwr_hi", {31'b0, mem_DMWr}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_dmwr_lo", {31'b0, mem_DMWr}, 32'd0);
    check("rr_ready",   {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rr_noresp", {31'b0, seen}, 32'd0);
    check("rr_mem1",   mem[1], 32'h0000_0055);
    check("rr_ready2", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    check("rr_next",     r_data, 32'h0000_0055);
    check("rr_next_lat", r_lat, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
